// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// The control word is ordered as the pipeline is: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        IFLUSH = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_flush;
        logic exmem_write;
        logic memwb_write;
    } ctrl_t;

    // Free-running pipe: every stage loads, nothing is squashed.
    localparam ctrl_t CTRL_RUN    = 7'b1100011;
    localparam ctrl_t CTRL_FREEZE = 7'b0000000;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard inputs from the datapath and sequencing outputs back to it.
// master = datapath side, slave = the controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt_addr;
    logic             branch_taken;
    logic             icache_stall;
    logic             dcache_stall;
    logic             clr_cnt;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_write;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] lu_cnt;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rt, ex_memread, ex_rt_addr,
               branch_taken, icache_stall, dcache_stall, clr_cnt,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush,
               exmem_write, memwb_write, stall_cnt, flush_cnt, lu_cnt
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rt, ex_memread, ex_rt_addr,
               branch_taken, icache_stall, dcache_stall, clr_cnt,
        output pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush,
               exmem_write, memwb_write, stall_cnt, flush_cnt, lu_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: sticks at all-ones, synchronous clear beats increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencer for the 5-stage core: load-use bubbles, branch flushes, cache-miss freezes,
// and a redirect that lands while the I-cache is still missing (IFLUSH).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   lu;
    logic   lu_bubble;

    assign lu = hz.ex_memread && (hz.ex_rt_addr != REG_ZERO) &&
                ((hz.ex_rt_addr == hz.id_rs_addr) ||
                 (hz.id_uses_rt && (hz.ex_rt_addr == hz.id_rt_addr)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (hz.dcache_stall) begin
            if (state_q != IFLUSH)
                state_d = DSTALL;
        end else if (state_q == IFLUSH) begin
            if (!hz.icache_stall)
                state_d = RUN;
        end else begin
            // DSTALL releasing behaves exactly like RUN in the same cycle.
            state_d = (hz.branch_taken && hz.icache_stall) ? IFLUSH : RUN;
        end
    end

    always_comb begin
        ctrl      = CTRL_RUN;
        lu_bubble = 1'b0;
        if (rst) begin
            ctrl = CTRL_FREEZE;
        end else if (hz.dcache_stall) begin
            ctrl = CTRL_FREEZE;
        end else if (state_q == IFLUSH) begin
            // PC already holds the branch target; only the wrong-path fetch must die.
            ctrl.pc_write = 1'b0;
            if (hz.icache_stall) begin
                ctrl.ifid_write  = 1'b0;
                ctrl.idex_bubble = 1'b1;
            end else begin
                ctrl.ifid_flush = 1'b1;
            end
        end else if (hz.branch_taken) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (lu || hz.icache_stall) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.idex_bubble = 1'b1;
            lu_bubble        = lu;
        end
    end

    assign hz.pc_write    = ctrl.pc_write;
    assign hz.ifid_write  = ctrl.ifid_write;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_bubble = ctrl.idex_bubble;
    assign hz.idex_flush  = ctrl.idex_flush;
    assign hz.exmem_write = ctrl.exmem_write;
    assign hz.memwb_write = ctrl.memwb_write;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .inc_i(!ctrl.pc_write), .clr_i(hz.clr_cnt), .cnt_o(hz.stall_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .inc_i(ctrl.idex_flush), .clr_i(hz.clr_cnt), .cnt_o(hz.flush_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk(clk), .rst(rst), .inc_i(lu_bubble), .clr_i(hz.clr_cnt), .cnt_o(hz.lu_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a reference model queues the expected control word and
// counters for each driven cycle; every scenario task pops and compares them.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int OBS_W = 7 + 3 * CNT_W;

    typedef logic [OBS_W-1:0] obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t sb_q[$];
    obs_t obs, expv;

    // Reference model state: 0 = RUN, 1 = DSTALL, 2 = IFLUSH
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_lu    = 0;

    function automatic obs_t observe();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.idex_flush,
                hz.exmem_write, hz.memwb_write, hz.stall_cnt, hz.flush_cnt, hz.lu_cnt};
    endfunction

    function automatic int sat_inc(input int v, input bit inc);
        if (inc && v < CMAX) return v + 1;
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_stall = 0; m_flush = 0; m_lu = 0;
    endtask

    task automatic drive_cycle(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                               input logic mr, input logic [4:0] ert, input logic br,
                               input logic ic, input logic dc, input logic clr);
        bit pc, iw, ifl, bub, ifx, em, mw, luh, lub;
        logic [CNT_W-1:0] s, f, l;
        @(negedge clk);
        hz.id_rs_addr = rs; hz.id_rt_addr = rt; hz.id_uses_rt = urt;
        hz.ex_memread = mr; hz.ex_rt_addr = ert; hz.branch_taken = br;
        hz.icache_stall = ic; hz.dcache_stall = dc; hz.clr_cnt = clr;
        luh = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
        lub = 0;
        {pc, iw, ifl, bub, ifx, em, mw} = 7'b1100011;
        if (rst)                 {pc, iw, ifl, bub, ifx, em, mw} = 7'b0;
        else if (dc)             {pc, iw, ifl, bub, ifx, em, mw} = 7'b0;
        else if (m_state == 2)   {pc, iw, ifl, bub, ifx, em, mw} = ic ? 7'b0001011 : 7'b0110011;
        else if (br)             {pc, iw, ifl, bub, ifx, em, mw} = 7'b1110111;
        else if (luh || ic) begin
            {pc, iw, ifl, bub, ifx, em, mw} = 7'b0001011;
            lub = luh;
        end
        s = m_stall[CNT_W-1:0]; f = m_flush[CNT_W-1:0]; l = m_lu[CNT_W-1:0];
        sb_q.push_back({pc, iw, ifl, bub, ifx, em, mw, s, f, l});
        if (rst) begin
            model_reset();
        end else begin
            if (clr) begin
                m_stall = 0; m_flush = 0; m_lu = 0;
            end else begin
                m_stall = sat_inc(m_stall, !pc);
                m_flush = sat_inc(m_flush, ifx);
                m_lu    = sat_inc(m_lu, lub);
            end
            if (dc)                m_state = (m_state == 2) ? 2 : 1;
            else if (m_state == 2) m_state = ic ? 2 : 0;
            else                   m_state = (br && ic) ? 2 : 0;
        end
        #1;
    endtask

    task automatic idle(input logic clr);
        drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, clr);
    endtask

    task automatic test_reset();
        hz.id_rs_addr = 0; hz.id_rt_addr = 0; hz.id_uses_rt = 0; hz.ex_memread = 0;
        hz.ex_rt_addr = 0; hz.branch_taken = 0; hz.icache_stall = 0; hz.dcache_stall = 0;
        hz.clr_cnt = 0;
        #2;
        obs = observe(); n_tests++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_outputs got %h want %h", obs, obs_t'(0));
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            obs = observe(); expv = sb_q.pop_front(); n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL reset_run cyc%0d got %h want %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_load_use();
        logic [4:0] tab [6][6] = '{
            '{5'd8, 5'd0, 5'd0, 5'd1, 5'd8, 5'd0},   // rs hit (T1)
            '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},   // idle
            '{5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0},   // $zero never hazards (T2)
            '{5'd3, 5'd9, 5'd1, 5'd1, 5'd9, 5'd0},   // rt hit, rt used
            '{5'd3, 5'd9, 5'd0, 5'd1, 5'd9, 5'd0},   // rt match but not a source
            '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 5'd0}    // not a load
        };
        idle(1'b1);
        void'(sb_q.pop_front());
        for (int i = 0; i < 6; i++) begin
            drive_cycle(tab[i][0], tab[i][1], tab[i][2][0], tab[i][3][0], tab[i][4],
                        1'b0, 1'b0, 1'b0, 1'b0);
            obs = observe(); expv = sb_q.pop_front(); n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL load_use row%0d got %h want %h", i, obs, expv);
            end
        end
        idle(1'b0);
        void'(sb_q.pop_front());
        n_tests++;
        if (hz.lu_cnt !== 8'd2) begin
            n_fail++; $display("FAIL lu_cnt_total got %0d want 2", hz.lu_cnt);
        end
    endtask

    task automatic test_dstall_branch();
        idle(1'b1);
        void'(sb_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, (i < 4), 1'b0);
            obs = observe(); expv = sb_q.pop_front(); n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL dstall_branch cyc%0d got %h want %h", i, obs, expv);
            end
        end
        idle(1'b0);
        void'(sb_q.pop_front());
        n_tests++;
        if (hz.stall_cnt !== 8'd4 || hz.flush_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL dstall_counts got stall=%0d flush=%0d want stall=4 flush=1",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_iflush();
        // {br, ic, dc} per cycle; second half parks a D-miss inside IFLUSH.
        logic [2:0] seq [12] = '{3'b110, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                                 3'b110, 3'b011, 3'b001, 3'b010, 3'b000, 3'b000};
        logic [2:0] cur;
        idle(1'b1);
        void'(sb_q.pop_front());
        for (int i = 0; i < 12; i++) begin
            cur = seq[i];
            drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, cur[2], cur[1], cur[0], 1'b0);
            obs = observe(); expv = sb_q.pop_front(); n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL iflush cyc%0d got %h want %h", i, obs, expv);
            end
        end
        n_tests++;
        if (hz.flush_cnt !== 8'd2) begin
            n_fail++; $display("FAIL iflush_flush_cnt got %0d want 2", hz.flush_cnt);
        end
    endtask

    task automatic test_combo();
        idle(1'b1);
        void'(sb_q.pop_front());
        drive_cycle(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        obs = observe(); expv = sb_q.pop_front(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL combo_lu_ic got %h want %h", obs, expv);
        end
        drive_cycle(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        obs = observe(); expv = sb_q.pop_front(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL combo_lu_br got %h want %h", obs, expv);
        end
        idle(1'b0);
        void'(sb_q.pop_front());
        n_tests++;
        if (hz.lu_cnt !== 8'd1 || hz.flush_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL combo_counts got lu=%0d flush=%0d want lu=1 flush=1",
                     hz.lu_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        void'(sb_q.pop_front());
        drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        void'(sb_q.pop_front());
        #1 rst = 1'b1;
        model_reset();
        #1;
        obs = observe(); n_tests++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL rst_mid_async got %h want %h", obs, obs_t'(0));
        end
        drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        obs = observe(); expv = sb_q.pop_front(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL rst_mid_hold got %h want %h", obs, expv);
        end
        @(posedge clk); #1 rst = 1'b0;
        // Pending redirect must be gone: an idle cycle is plain RUN, not an IFLUSH flush.
        idle(1'b0);
        obs = observe(); expv = sb_q.pop_front(); n_tests++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL rst_mid_run got %h want %h", obs, expv);
        end
    endtask

    task automatic test_saturation();
        idle(1'b1);
        void'(sb_q.pop_front());
        for (int i = 0; i < CMAX + 6; i++) begin
            drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            obs = observe(); expv = sb_q.pop_front(); n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL sat cyc%0d got %h want %h", i, obs, expv);
            end
        end
        n_tests++;
        if (hz.stall_cnt !== 8'hFF) begin
            n_fail++; $display("FAIL sat_stall got %h want ff", hz.stall_cnt);
        end
        drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        void'(sb_q.pop_front());
        idle(1'b0);
        void'(sb_q.pop_front());
        n_tests++;
        if (hz.stall_cnt !== 8'h00) begin
            n_fail++; $display("FAIL sat_clr_wins got %h want 00", hz.stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [4:0] rs, rt, ert;
        for (int i = 0; i < 400; i++) begin
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            ert = 5'($urandom_range(0, 3));
            drive_cycle(rs, rt, 1'($urandom), 1'($urandom), ert,
                        ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                        ($urandom_range(0, 4) == 0), ($urandom_range(0, 40) == 0));
            obs = observe(); expv = sb_q.pop_front(); n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random cyc%0d got %h want %h", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dstall_branch();
        test_iflush();
        test_combo();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
